hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core (IF, ID, EX, MEM, WB). It tracks the destination registers of the instructions in EX, MEM and WB. It stalls IF/ID on load-use and, when configured without forwarding, on any RAW hazard. For the instruction entering EX, it produces the registered operand-forwarding selects that drive the ALU's source/destination operand muxes.

## Interface
- `NREG` — 8 — number of GPRs; register index width is clog2(NREG) = 3.
- `clk` input 1 — sole clock, rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `id_valid` input 1 — ID holds a real instruction.
- `id_src` input 3 — ID source register index.
- `id_dst` input 3 — ID destination register index; also the second ALU operand.
- `id_use_src` / `id_use_dst` input 1 each — ID instruction reads that operand.
- `id_wb` input 1 — ID instruction writes `id_dst`.
- `id_mem_read` input 1 — ID instruction is a load.
- `flush` input 1 — branch taken in EX; squash the ID instruction.
- `mem_busy` input 1 — data memory not ready; freeze the whole pipeline.
- `stall` output 1 — hold PC and IF/ID this cycle (combinational).
- `ex_valid` output 1 — EX slot holds a real instruction (registered).
- `ex_fwd_src_sel` / `ex_fwd_dst_sel` output 2 each — EX operand select (registered):
  - 0 = register file
  - 1 = previous ALU result (EX/MEM)
  - 2 = older result (MEM/WB)
  - 3 = load data (MEM/WB)
- `stall_count` output 16 — saturating count of hazard-stall cycles.

## Operation
- Internal scoreboard: three slots, EX → MEM → WB. Each slot holds {valid, wb, mem_read, dst[2:0]}.
- The register file writes through, so the WB slot never causes a hazard.
- Match(slot, op): `slot.valid & slot.wb & id_use_op & (slot.dst == id_op)`, where op ∈ {src, dst}.
- Hazard:
  - With forwarding: any op matches the EX slot and `EX.mem_read` = 1.
  - Without forwarding: any op matches the EX slot or the MEM slot.
- `stall` = `id_valid & hazard & ~flush`, OR `mem_busy`.
- Advance (`mem_busy` = 0), applied each clock:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← ID fields with valid = `id_valid & ~hazard & ~flush`. A hazard or flush inserts a bubble.
- Freeze (`mem_busy` = 1): all slots, selects and `ex_valid` hold their values.
  - `stall_count` does not increment on freeze-only cycles.
- Forward select for an op, evaluated in ID and registered on advance:
  - EX-slot match → 1.
  - Otherwise MEM-slot match → 3 if `MEM.mem_read`, else 2.
  - Otherwise 0.
  - The newest producer wins.
  - A bubble writes 0.
- `stall_count` increments when `id_valid & hazard & ~flush & ~mem_busy`. It saturates at 0xFFFF.
- `flush` has priority over hazard: the squashed instruction never stalls and never enters EX.

## Timing
- Reset: all slots invalid; `ex_valid` = 0; both selects = 0; `stall_count` = 0; `stall` = 0 while `rst_n` = 0.
- Reset applied mid-stall clears the scoreboard on the next edge; no stall survives reset.
- Load-use with forwarding: exactly 1 stall cycle.
  - The consumer then enters EX with select 3 while the load is in WB.
- Without forwarding:
  - Producer distance 1 → 2 stall cycles.
  - Producer distance 2 → 1 stall cycle.
- Selects are valid from the clock edge on which the instruction enters EX. They are stable for that EX cycle and for any freeze cycles that follow.
- `flush` and hazard in the same cycle: `stall` = 0, and a bubble enters EX.
- `mem_busy` and hazard in the same cycle: `stall` = 1, with no slot movement. The hazard is re-evaluated after the freeze.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Only load-use stalls occur.
  - Selects are computed as above.
- `HAZARD_FWD_EN` undefined:
  - Full interlock on EX/MEM producers.
  - `ex_fwd_src_sel` and `ex_fwd_dst_sel` are tied to 0.
  - The hazard rule is the "without forwarding" rule.

## Test plan
- `ADD R1,R2`, then `SUB R3,R1` back-to-back, forwarding on:
  - No stall.
  - SUB enters EX with `ex_fwd_dst_sel`=0 and `ex_fwd_src_sel`=1, per the R1 operand position.
  - `stall_count` stays 0.
- `LDD R4`, then `ADD R4,R5`, forwarding on:
  - `stall`=1 for exactly 1 cycle, and a bubble is inserted (`ex_valid`=0).
  - ADD then enters EX with select 3 on the R4 operand.
  - `stall_count`=1.
- The same two sequences with forwarding off:
  - Stalls of 2 and 2 cycles respectively.
  - All selects 0.
  - `stall_count`=4.
- LDD R4 in EX, consumer in ID, `flush`=1 on the same cycle:
  - `stall`=0.
  - The next cycle has `ex_valid`=0.
  - `stall_count` unchanged.
- Hazard pending, `mem_busy`=1 for 3 cycles:
  - `stall`=1 throughout, with slots and selects frozen.
  - After release, exactly 1 hazard stall, and `stall_count` increments by 1.
- `rst_n`=0 during a load-use stall:
  - Next cycle `stall`=0, `ex_valid`=0, selects 0, `stall_count`=0.
- Force 65536 stall cycles:
  - `stall_count` holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core (IF, ID, EX, MEM, WB).
//
// Tracks the destination registers of in-flight instructions. It stalls IF/ID on a
// load-use hazard. When built without forwarding, it stalls on any RAW hazard against
// EX or MEM. It also produces registered operand-forwarding selects for the instruction
// entering EX.
//
// Build option: define HAZARD_FWD_EN to enable forwarding.
//   - Defined: only load-use hazards stall, and the selects are live.
//   - Undefined: full interlock on EX/MEM producers, and both selects are tied to 0.
//
// Ports:
//   clk, rst_n                rising-edge clock, synchronous active-low reset
//   id_valid                  ID holds a real instruction
//   id_src, id_dst            ID source / destination (second ALU operand) indices
//   id_use_src, id_use_dst    ID instruction reads that operand
//   id_wb, id_mem_read        ID instruction writes id_dst / is a load
//   flush                     branch taken in EX: squash the ID instruction
//   mem_busy                  data memory not ready: freeze the whole pipeline
//   stall                     hold PC and IF/ID this cycle (combinational)
//   ex_valid                  EX slot holds a real instruction (registered)
//   ex_fwd_src_sel/_dst_sel   EX operand select: 0 regfile, 1 EX/MEM ALU,
//                             2 MEM/WB ALU, 3 MEM/WB load data (registered)
//   stall_count               saturating count of hazard-stall cycles
module hazard_ctrl #(
    parameter int unsigned NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [$clog2(NREG)-1:0] id_src,
    input  logic [$clog2(NREG)-1:0] id_dst,
    input  logic                    id_use_src,
    input  logic                    id_use_dst,
    input  logic                    id_wb,
    input  logic                    id_mem_read,
    input  logic                    flush,
    input  logic                    mem_busy,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [1:0]              ex_fwd_src_sel,
    output logic [1:0]              ex_fwd_dst_sel,
    output logic [15:0]             stall_count
);

    localparam int unsigned RW = $clog2(NREG);

    // The scoreboard keeps only the EX and MEM slots. The register file writes
    // through, so a producer in WB is already visible to ID and needs no tracking.
    logic          ex_valid_q, ex_wb_q, ex_ld_q;
    logic [RW-1:0] ex_dst_q;
    logic          mem_valid_q, mem_wb_q, mem_ld_q;
    logic [RW-1:0] mem_dst_q;
    logic [1:0]    src_sel_q, dst_sel_q;
    logic [15:0]   stall_count_q;

    logic [1:0]    src_sel_d, dst_sel_d;
    logic          ex_hit_src, ex_hit_dst, mem_hit_src, mem_hit_dst;
    logic          hazard, hz_stall, issue;

    assign ex_hit_src  = ex_valid_q & ex_wb_q & id_use_src & (ex_dst_q == id_src);
    assign ex_hit_dst  = ex_valid_q & ex_wb_q & id_use_dst & (ex_dst_q == id_dst);
    assign mem_hit_src = mem_valid_q & mem_wb_q & id_use_src & (mem_dst_q == id_src);
    assign mem_hit_dst = mem_valid_q & mem_wb_q & id_use_dst & (mem_dst_q == id_dst);

`ifdef HAZARD_FWD_EN
    assign hazard = (ex_hit_src | ex_hit_dst) & ex_ld_q;

    // The EX producer is newer than the MEM producer, so it is checked first.
    always_comb begin
        src_sel_d = 2'd0;
        if (ex_hit_src) begin
            src_sel_d = 2'd1;
        end else if (mem_hit_src) begin
            src_sel_d = mem_ld_q ? 2'd3 : 2'd2;
        end
        dst_sel_d = 2'd0;
        if (ex_hit_dst) begin
            dst_sel_d = 2'd1;
        end else if (mem_hit_dst) begin
            dst_sel_d = mem_ld_q ? 2'd3 : 2'd2;
        end
    end
`else
    assign hazard = ex_hit_src | ex_hit_dst | mem_hit_src | mem_hit_dst;

    always_comb begin
        src_sel_d = 2'd0;
        dst_sel_d = 2'd0;
    end

    // Without forwarding, load-ness never affects a decision.
    logic unused_ld;
    assign unused_ld = ex_ld_q ^ mem_ld_q;
`endif

    // flush outranks hazard: a squashed instruction neither stalls nor issues.
    assign hz_stall = id_valid & hazard & ~flush;
    assign issue    = id_valid & ~hazard & ~flush;
    assign stall    = rst_n & (hz_stall | mem_busy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_wb_q       <= 1'b0;
            ex_ld_q       <= 1'b0;
            ex_dst_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_wb_q      <= 1'b0;
            mem_ld_q      <= 1'b0;
            mem_dst_q     <= '0;
            src_sel_q     <= 2'd0;
            dst_sel_q     <= 2'd0;
            stall_count_q <= 16'd0;
        end else if (!mem_busy) begin
            mem_valid_q <= ex_valid_q;
            mem_wb_q    <= ex_wb_q;
            mem_ld_q    <= ex_ld_q;
            mem_dst_q   <= ex_dst_q;
            ex_valid_q  <= issue;
            ex_wb_q     <= id_wb;
            ex_ld_q     <= id_mem_read;
            ex_dst_q    <= id_dst;
            // A bubble always carries register-file selects.
            src_sel_q   <= issue ? src_sel_d : 2'd0;
            dst_sel_q   <= issue ? dst_sel_d : 2'd0;
            if (hz_stall && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_fwd_src_sel = src_sel_q;
    assign ex_fwd_dst_sel = dst_sel_q;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// The bench runs the directed scenarios, then randomized traffic, against a
// producer-age reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_use_src, id_use_dst, id_wb, id_mem_read;
    logic        flush, mem_busy;
    logic [2:0]  id_src, id_dst;
    logic        stall, ex_valid;
    logic [1:0]  ex_fwd_src_sel, ex_fwd_dst_sel;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.NREG(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_src         (id_src),
        .id_dst         (id_dst),
        .id_use_src     (id_use_src),
        .id_use_dst     (id_use_dst),
        .id_wb          (id_wb),
        .id_mem_read    (id_mem_read),
        .flush          (flush),
        .mem_busy       (mem_busy),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_fwd_src_sel (ex_fwd_src_sel),
        .ex_fwd_dst_sel (ex_fwd_dst_sel),
        .stall_count    (stall_count)
    );

`ifdef HAZARD_FWD_EN
    localparam int ExpSubStalls  = 0;
    localparam int ExpSubSrcSel  = 1;
    localparam int ExpLdStalls   = 1;
    localparam int ExpLdDstSel   = 3;
`else
    localparam int ExpSubStalls  = 2;
    localparam int ExpSubSrcSel  = 0;
    localparam int ExpLdStalls   = 2;
    localparam int ExpLdDstSel   = 0;
`endif

    typedef struct packed {
        logic       v;
        logic       us;
        logic       ud;
        logic       wb;
        logic       ld;
        logic [2:0] s;
        logic [2:0] d;
    } ins_t;

    typedef struct packed {
        logic       valid;
        logic       wb;
        logic       ld;
        logic [2:0] dst;
    } prod_t;

    // Reference model: in-flight instructions by age (0 = one stage ahead of ID).
    prod_t      pipe [3];
    logic [1:0] m_src_sel, m_dst_sel;
    int         m_count;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic us, input logic ud,
                                input logic wb, input logic ld,
                                input logic [2:0] s, input logic [2:0] d);
        ins_t i;
        i.v = v; i.us = us; i.ud = ud; i.wb = wb; i.ld = ld; i.s = s; i.d = d;
        return i;
    endfunction

    // Age of the newest still-unwritten producer of register r (-1 if none).
    function automatic int prod_age(input logic use_op, input logic [2:0] r);
        if (use_op) begin
            for (int a = 0; a < 2; a++) begin
                if (pipe[a].valid && pipe[a].wb && pipe[a].dst == r) return a;
            end
        end
        return -1;
    endfunction

    function automatic logic op_hazard(input int age);
`ifdef HAZARD_FWD_EN
        return (age == 0) && pipe[0].ld;
`else
        return age >= 0;
`endif
    endfunction

    function automatic logic [1:0] op_sel(input int age);
`ifdef HAZARD_FWD_EN
        if (age == 0) return 2'd1;
        if (age == 1) return pipe[1].ld ? 2'd3 : 2'd2;
`endif
        return 2'd0;
    endfunction

    // One clock: drive at negedge, check stall, advance model, check registered outputs.
    task automatic cycle(input ins_t i, input logic fl, input logic mb,
                         output logic issued, output logic saw_stall);
        int   as, ad;
        logic hz, exp_stall;
        id_valid = i.v; id_use_src = i.us; id_use_dst = i.ud; id_wb = i.wb;
        id_mem_read = i.ld; id_src = i.s; id_dst = i.d; flush = fl; mem_busy = mb;
        #1;
        as = prod_age(i.us, i.s);
        ad = prod_age(i.ud, i.d);
        hz = op_hazard(as) | op_hazard(ad);
        exp_stall = rst_n && ((i.v && hz && !fl) || mb);
        saw_stall = stall;
        check("stall", int'(stall), int'(exp_stall));
        issued = 1'b0;
        if (!rst_n) begin
            for (int a = 0; a < 3; a++) pipe[a] = '0;
            m_src_sel = 2'd0;
            m_dst_sel = 2'd0;
            m_count   = 0;
        end else if (!mb) begin
            issued = i.v && !hz && !fl;
            if (i.v && hz && !fl && m_count < 65535) m_count++;
            m_src_sel = issued ? op_sel(as) : 2'd0;
            m_dst_sel = issued ? op_sel(ad) : 2'd0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{valid: issued, wb: i.wb, ld: i.ld, dst: i.d};
        end
        @(posedge clk);
        @(negedge clk);
        check("ex_valid", int'(ex_valid), int'(pipe[0].valid));
        check("src_sel", int'(ex_fwd_src_sel), int'(m_src_sel));
        check("dst_sel", int'(ex_fwd_dst_sel), int'(m_dst_sel));
        check("stall_count", int'(stall_count), m_count);
    endtask

    // Hold an instruction in ID until it issues; returns the stall cycles seen.
    task automatic issue(input ins_t i, output int stalls);
        logic iss_l, s_l;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(i, 1'b0, 1'b0, iss_l, s_l);
            if (s_l) stalls++;
            if (iss_l) return;
        end
        check("issue_timeout", 0, 1);
    endtask

    ins_t nop, add12, sub31, ldd4, add45, ldchain;
    logic iss, s;
    int   st, exp_cnt;

    task automatic drain(input int n);
        logic iss_l, s_l;
        for (int k = 0; k < n; k++) cycle(nop, 1'b0, 1'b0, iss_l, s_l);
    endtask

    initial begin
        nop     = mk(0, 0, 0, 0, 0, 3'd0, 3'd0);
        add12   = mk(1, 1, 1, 1, 0, 3'd2, 3'd1);   // ADD R1,R2
        sub31   = mk(1, 1, 1, 1, 0, 3'd1, 3'd3);   // SUB R3,R1
        ldd4    = mk(1, 0, 0, 1, 1, 3'd0, 3'd4);   // LDD R4
        add45   = mk(1, 1, 1, 1, 0, 3'd5, 3'd4);   // ADD R4,R5
        ldchain = mk(1, 0, 1, 1, 1, 3'd0, 3'd4);   // load reading and writing R4

        rst_n = 1'b0;
        id_valid = 0; id_use_src = 0; id_use_dst = 0; id_wb = 0; id_mem_read = 0;
        id_src = 0; id_dst = 0; flush = 0; mem_busy = 1'b1;
        @(negedge clk);
        cycle(nop, 1'b0, 1'b1, iss, s);             // mem_busy during reset: no stall
        drain(1);
        rst_n = 1'b1;
        check("rst_ex_valid", int'(ex_valid), 0);
        check("rst_count", int'(stall_count), 0);

        // Back-to-back ALU dependency.
        issue(add12, st);
        check("add_stalls", st, 0);
        issue(sub31, st);
        check("sub_stalls", st, ExpSubStalls);
        check("sub_src_sel", int'(ex_fwd_src_sel), ExpSubSrcSel);
        check("sub_dst_sel", int'(ex_fwd_dst_sel), 0);
        exp_cnt = ExpSubStalls;
        check("sub_count", int'(stall_count), exp_cnt);

        // Load-use.
        drain(3);
        issue(ldd4, st);
        issue(add45, st);
        check("ld_stalls", st, ExpLdStalls);
        check("ld_dst_sel", int'(ex_fwd_dst_sel), ExpLdDstSel);
        check("ld_src_sel", int'(ex_fwd_src_sel), 0);
        exp_cnt += ExpLdStalls;
        check("ld_count", int'(stall_count), exp_cnt);

        // Flush together with a hazard.
        drain(3);
        issue(ldd4, st);
        cycle(add45, 1'b1, 1'b0, iss, s);
        check("flush_stall", int'(s), 0);
        check("flush_bubble", int'(ex_valid), 0);
        check("flush_count", int'(stall_count), exp_cnt);

        // Hazard pending under a 3-cycle freeze.
        drain(3);
        issue(ldd4, st);
        for (int k = 0; k < 3; k++) begin
            cycle(add45, 1'b0, 1'b1, iss, s);
            check("busy_stall", int'(s), 1);
            check("busy_ex_valid", int'(ex_valid), 1);
            check("busy_count", int'(stall_count), exp_cnt);
        end
        issue(add45, st);
        check("busy_release_stalls", st, ExpLdStalls);
        exp_cnt += ExpLdStalls;
        check("busy_release_count", int'(stall_count), exp_cnt);

        // Reset during a load-use stall.
        drain(3);
        issue(ldd4, st);
        rst_n = 1'b0;
        cycle(add45, 1'b0, 1'b0, iss, s);
        check("rst_mid_stall", int'(s), 0);
        check("rst_mid_ex_valid", int'(ex_valid), 0);
        check("rst_mid_src_sel", int'(ex_fwd_src_sel), 0);
        check("rst_mid_dst_sel", int'(ex_fwd_dst_sel), 0);
        check("rst_mid_count", int'(stall_count), 0);
        rst_n = 1'b1;
        cycle(add45, 1'b0, 1'b0, iss, s);
        check("post_rst_stall", int'(s), 0);

        // Saturation: preload the counter close to the top, then keep stalling.
        drain(3);
        force dut.stall_count_q = 16'hFFF8;
        #1;
        release dut.stall_count_q;
        m_count = 16'hFFF8;
        for (int k = 0; k < 12; k++) issue(ldchain, st);
        check("sat_count", int'(stall_count), 16'hFFFF);

        // Randomized traffic on a small register window to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            ins_t r;
            rst_n = ($urandom_range(0, 99) != 0);
            r = mk(($urandom_range(0, 99) < 85), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)));
            cycle(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), iss, s);
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
